// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and legal parameter limits.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

    localparam int DBIT_MIN = 5;
    localparam int DBIT_MAX = 8;
    localparam int OVS_MIN  = 8;
    localparam int OVS_MAX  = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } uart_state_e;

    function automatic int maxInt(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/uart_tx_ctrl.sv
// UART transmitter FSM driven by an external oversample strobe (s_tick).
// Optional parity bit after the data bits when UART_TX_PARITY_EN is defined.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int OVS     = 16,
    parameter int SB_TICK = 16
`ifdef UART_TX_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_tick,
    input  logic       tx_start,
    input  logic [7:0] din,
    output logic       tx_busy,
    output logic       tx_done_tick,
    output logic       tx
);

    localparam int S_W = $clog2(maxInt(OVS, SB_TICK));

    localparam logic [S_W-1:0] S_BIT_LAST  = S_W'(OVS - 1);
    localparam logic [S_W-1:0] S_STOP_LAST = S_W'(SB_TICK - 1);
    localparam logic [2:0]     N_LAST      = 3'(DBIT - 1);

    uart_state_e       state_q, state_d;
    logic [S_W-1:0]    s_q, s_d;
    logic [2:0]        n_q, n_d;
    logic [DBIT-1:0]   b_q, b_d;
    logic              tx_q, tx_d;
    logic              doneTick;
`ifdef UART_TX_PARITY_EN
    logic              par_q, par_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // tx_d selects the line level for the current state; tx_q presents it one cycle later.
    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        n_d      = n_q;
        b_d      = b_q;
        tx_d     = tx_q;
        doneTick = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d    = par_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (tx_start) begin
                    state_d = ST_START;
                    s_d     = '0;
                    n_d     = '0;
                    b_d     = din[DBIT-1:0];
`ifdef UART_TX_PARITY_EN
                    par_d   = (^din[DBIT-1:0]) ^ PARITY_ODD;
`endif
                end
            end
            ST_START: begin
                tx_d = 1'b0;
                if (s_tick) begin
                    if (s_q == S_BIT_LAST) begin
                        state_d = ST_DATA;
                        s_d     = '0;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                tx_d = b_q[0];
                if (s_tick) begin
                    if (s_q == S_BIT_LAST) begin
                        s_d = '0;
                        b_d = b_q >> 1;
                        if (n_q == N_LAST) begin
`ifdef UART_TX_PARITY_EN
                            state_d = ST_PARITY;
`else
                            state_d = ST_STOP;
`endif
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                tx_d = par_q;
                if (s_tick) begin
                    if (s_q == S_BIT_LAST) begin
                        state_d = ST_STOP;
                        s_d     = '0;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
`endif
            ST_STOP: begin
                tx_d = 1'b1;
                if (s_tick) begin
                    if (s_q == S_STOP_LAST) begin
                        state_d  = ST_IDLE;
                        doneTick = 1'b1;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign tx_busy      = (state_q != ST_IDLE);
    assign tx_done_tick = doneTick;
    assign tx           = tx_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed testbench for uart_tx_ctrl: default-stop instance plus a 2-stop-bit instance.
// Parity expectations switch on when UART_TX_PARITY_EN is defined.
module tb_uart_tx_ctrl;

`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_tick = 1'b1;
    logic       start0 = 1'b0;
    logic       start1 = 1'b0;
    logic [7:0] din = 8'h00;
    logic       tx0, busy0, done0;
    logic       tx1, busy1, done1;

    int vectors = 0;
    int miscompares = 0;

    int tickPeriod = 1;
    int tickCnt = 0;

    logic txTr   [0:1023];
    logic busyTr [0:1023];
    logic doneTr [0:1023];

    uart_tx_ctrl #(
        .DBIT(8), .OVS(16), .SB_TICK(16)
`ifdef UART_TX_PARITY_EN
        , .PARITY_ODD(1'b0)
`endif
    ) dut0 (
        .clk(clk), .rst(rst), .s_tick(s_tick), .tx_start(start0), .din(din),
        .tx_busy(busy0), .tx_done_tick(done0), .tx(tx0)
    );

    uart_tx_ctrl #(
        .DBIT(8), .OVS(16), .SB_TICK(32)
`ifdef UART_TX_PARITY_EN
        , .PARITY_ODD(1'b1)
`endif
    ) dut1 (
        .clk(clk), .rst(rst), .s_tick(s_tick), .tx_start(start1), .din(din),
        .tx_busy(busy1), .tx_done_tick(done1), .tx(tx1)
    );

    always #5 clk = ~clk;

    // Oversample strobe: one pulse every tickPeriod clocks, updated just after each rising edge.
    always @(posedge clk) begin
        #2;
        tickCnt = (tickCnt + 1) % tickPeriod;
        s_tick  = (tickCnt == tickPeriod - 1);
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Index 0 is the first cycle after the accepting edge; stops at the first non-busy cycle.
    task automatic captureFrame(input int sel, input bit dropStart, input int maxCycles,
                                output int busyLen, output int doneIdx, output int doneCnt);
        busyLen = -1;
        doneIdx = -1;
        doneCnt = 0;
        for (int i = 0; i < maxCycles; i++) begin
            @(negedge clk);
            txTr[i]   = (sel == 0) ? tx0   : tx1;
            busyTr[i] = (sel == 0) ? busy0 : busy1;
            doneTr[i] = (sel == 0) ? done0 : done1;
            if (i == 0 && dropStart) begin
                if (sel == 0) start0 = 1'b0;
                else          start1 = 1'b0;
            end
            if (doneTr[i]) begin
                doneCnt++;
                if (doneIdx < 0) doneIdx = i;
            end
            if (!busyTr[i]) begin
                busyLen = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++; if (tx0 !== 1'b1)   begin miscompares++; $display("[TB] FAIL reset_tx0 got %b want 1", tx0); end
        vectors++; if (busy0 !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy0 got %b want 0", busy0); end
        vectors++; if (done0 !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done0 got %b want 0", done0); end
        vectors++; if (tx1 !== 1'b1)   begin miscompares++; $display("[TB] FAIL reset_tx1 got %b want 1", tx1); end
        vectors++; if (busy1 !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy1 got %b want 0", busy1); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (busy0 !== 1'b0 || tx0 !== 1'b1) begin
            miscompares++; $display("[TB] FAIL idle_after_reset busy=%b tx=%b want busy=0 tx=1", busy0, tx0);
        end
    endtask

    task automatic test_frame_a5();
        int busyLen, doneIdx, doneCnt;
        int expBits[11];
        expBits = '{0, 1, 0, 1, 0, 0, 1, 0, 1, (PAR == 1) ? 0 : 1, 1};
        tickPeriod = 1;
        @(negedge clk);
        din = 8'hA5;
        start0 = 1'b1;
        captureFrame(0, 1'b1, 400, busyLen, doneIdx, doneCnt);
        for (int k = 0; k < 10 + PAR; k++) begin
            vectors++;
            if (txTr[16 * k + 9] !== expBits[k][0]) begin
                miscompares++;
                $display("[TB] FAIL a5_bit%0d got %b want %0d", k, txTr[16 * k + 9], expBits[k]);
            end
        end
        vectors++; if (busyLen != 160 + 16 * PAR) begin miscompares++; $display("[TB] FAIL a5_busy_len got %0d want %0d", busyLen, 160 + 16 * PAR); end
        vectors++; if (doneIdx != 159 + 16 * PAR) begin miscompares++; $display("[TB] FAIL a5_done_idx got %0d want %0d", doneIdx, 159 + 16 * PAR); end
        vectors++; if (doneCnt != 1) begin miscompares++; $display("[TB] FAIL a5_done_count got %0d want 1", doneCnt); end
    endtask

    task automatic test_slow_tick();
        int busyLen, doneIdx, doneCnt, lowCnt;
        int lowEnd;
        lowEnd = 64 * (9 + PAR);
        @(negedge clk);
        tickPeriod = 4;
        tickCnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (s_tick) break;
        end
        vectors++; if (s_tick !== 1'b1) begin miscompares++; $display("[TB] FAIL slow_tick_phase got %b want 1", s_tick); end
        din = 8'h00;
        start0 = 1'b1;
        fork
            captureFrame(0, 1'b1, 900, busyLen, doneIdx, doneCnt);
            begin
                repeat (100) @(negedge clk);
                din = 8'hFF;
                start0 = 1'b1;
                repeat (300) @(negedge clk);
                start0 = 1'b0;
                din = 8'h00;
            end
        join
        lowCnt = 0;
        for (int i = 1; i <= lowEnd; i++) if (txTr[i] === 1'b0) lowCnt++;
        vectors++; if (lowCnt != lowEnd) begin miscompares++; $display("[TB] FAIL slow_low_count got %0d want %0d", lowCnt, lowEnd); end
        vectors++; if (txTr[lowEnd + 1] !== 1'b1) begin miscompares++; $display("[TB] FAIL slow_stop_edge got %b want 1", txTr[lowEnd + 1]); end
        vectors++; if (busyLen != 64 * (10 + PAR)) begin miscompares++; $display("[TB] FAIL slow_busy_len got %0d want %0d", busyLen, 64 * (10 + PAR)); end
        vectors++; if (doneIdx != 64 * (10 + PAR) - 1) begin miscompares++; $display("[TB] FAIL slow_done_idx got %0d want %0d", doneIdx, 64 * (10 + PAR) - 1); end
        tickPeriod = 1;
        tickCnt = 0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int busyLen, doneIdx, doneCnt;
        int exp3c[8];
        exp3c = '{0, 0, 1, 1, 1, 1, 0, 0};
        @(negedge clk);
        din = 8'h55;
        start0 = 1'b1;
        captureFrame(0, 1'b0, 400, busyLen, doneIdx, doneCnt);
        din = 8'h3C;
        vectors++; if (txTr[25] !== 1'b1 || txTr[41] !== 1'b0) begin
            miscompares++; $display("[TB] FAIL b2b_first_bits got %b%b want 10", txTr[25], txTr[41]);
        end
        vectors++; if (busyLen != 160 + 16 * PAR) begin miscompares++; $display("[TB] FAIL b2b_first_len got %0d want %0d", busyLen, 160 + 16 * PAR); end
        vectors++; if (doneIdx != busyLen - 1) begin miscompares++; $display("[TB] FAIL b2b_done_to_idle got done %0d idle %0d want idle one later", doneIdx, busyLen); end
        captureFrame(0, 1'b0, 400, busyLen, doneIdx, doneCnt);
        start0 = 1'b0;
        vectors++; if (busyTr[0] !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_second_start got %b want 1", busyTr[0]); end
        vectors++; if (txTr[9] !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_second_startbit got %b want 0", txTr[9]); end
        for (int k = 0; k < 8; k++) begin
            vectors++;
            if (txTr[16 * (k + 1) + 9] !== exp3c[k][0]) begin
                miscompares++;
                $display("[TB] FAIL b2b_3c_bit%0d got %b want %0d", k, txTr[16 * (k + 1) + 9], exp3c[k]);
            end
        end
        vectors++; if (busyLen != 160 + 16 * PAR) begin miscompares++; $display("[TB] FAIL b2b_second_len got %0d want %0d", busyLen, 160 + 16 * PAR); end
        repeat (3) @(negedge clk);
        vectors++; if (busy0 !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_no_third got %b want 0", busy0); end
    endtask

    task automatic test_stop32();
        int busyLen, doneIdx, doneCnt;
        @(negedge clk);
        din = 8'hA5;
        start1 = 1'b1;
        captureFrame(1, 1'b1, 400, busyLen, doneIdx, doneCnt);
        vectors++; if (txTr[153] !== 1'b1) begin miscompares++; $display("[TB] FAIL stop32_bit9 got %b want 1", txTr[153]); end
        vectors++; if (busyLen != 176 + 16 * PAR) begin miscompares++; $display("[TB] FAIL stop32_busy_len got %0d want %0d", busyLen, 176 + 16 * PAR); end
        vectors++; if (doneIdx != 175 + 16 * PAR) begin miscompares++; $display("[TB] FAIL stop32_done_idx got %0d want %0d", doneIdx, 175 + 16 * PAR); end
        vectors++; if (doneCnt != 1) begin miscompares++; $display("[TB] FAIL stop32_done_count got %0d want 1", doneCnt); end
    endtask

    task automatic test_reset_mid_frame();
        int bad;
        @(negedge clk);
        din = 8'hA5;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (73) @(negedge clk);
        vectors++; if (tx0 !== 1'b0 || busy0 !== 1'b1) begin
            miscompares++; $display("[TB] FAIL midrst_pre got tx=%b busy=%b want tx=0 busy=1", tx0, busy0);
        end
        #1;
        rst = 1'b1;
        #1;
        vectors++; if (tx0 !== 1'b1)   begin miscompares++; $display("[TB] FAIL midrst_tx got %b want 1", tx0); end
        vectors++; if (busy0 !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_busy got %b want 0", busy0); end
        vectors++; if (done0 !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_done got %b want 0", done0); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 250; i++) begin
            @(negedge clk);
            if (busy0 !== 1'b0 || done0 !== 1'b0 || tx0 !== 1'b1) bad++;
        end
        vectors++; if (bad != 0) begin miscompares++; $display("[TB] FAIL midrst_no_resume got %0d bad cycles want 0", bad); end
    endtask

    initial begin
        test_reset();
        test_frame_a5();
        test_slow_tick();
        test_back_to_back();
        test_stop32();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 SHALL have parameter DBIT, default 8, meaning data bits per frame (legal 5..8).
REQ-002 SHALL have parameter OVS, default 16, meaning s_tick pulses per bit period (legal 8 or 16).
REQ-003 SHALL have parameter SB_TICK, default 16, meaning s_tick pulses in the stop period (16 = 1 stop bit, 24 = 1.5, 32 = 2).
REQ-004 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port s_tick  input  1  one-cycle oversample strobe from the mod-M baud counter.
REQ-007 SHALL have port tx_start  input  1  request to send din; sampled only in IDLE.
REQ-008 SHALL have port din  input  8  data byte; bits [DBIT-1:0] are used.
REQ-009 SHALL have port tx_busy  output  1  high in every state except IDLE.
REQ-010 SHALL have port tx_done_tick  output  1  one-cycle pulse at the end of the stop period.
REQ-011 SHALL have port tx  output  1  serial line, idle high.

Function
REQ-012 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP, with PARITY present only under REQ-026.
REQ-013 In IDLE with tx_start=1, SHALL latch din into the shift register, clear the tick count s and bit count n, and enter START on the next edge.
REQ-014 SHALL ignore tx_start outside IDLE; the latched byte is not disturbed.
REQ-015 SHALL, in every non-IDLE state, increment s on each s_tick and hold s when s_tick=0.
REQ-016 SHALL leave START for DATA on the s_tick where s=OVS-1, clearing s.
REQ-017 SHALL, in DATA, drive tx from shift-register bit 0 (LSB first), and on the s_tick where s=OVS-1 shift right, clear s and increment n.
REQ-018 SHALL leave DATA on the s_tick where s=OVS-1 and n=DBIT-1, going to PARITY when enabled, otherwise STOP.
REQ-019 SHALL, in STOP, drive tx=1 and on the s_tick where s=SB_TICK-1 assert tx_done_tick for exactly that cycle and return to IDLE.
REQ-020 SHALL accept a tx_start in the first IDLE cycle after tx_done_tick, giving back-to-back frames with no extra idle bit.
REQ-021 SHALL not count an s_tick coincident with tx_start acceptance; the count starts at 0 in START.
REQ-022 SHALL register tx: tx changes one cycle after the state or shift edge that selects the new value, with no glitches.
REQ-023 SHALL size s as ceil(log2(max(OVS,SB_TICK))) bits and n as 3 bits, with no wrap-around inside a period.

Reset
REQ-024 SHALL, on rst=1 at any time including mid-frame, immediately force state=IDLE, s=0, n=0, shift register=0, tx=1, tx_busy=0 and tx_done_tick=0.
REQ-025 SHALL, after rst deasserts, require a fresh tx_start; an aborted frame is never resumed.

Configuration
REQ-026 SHALL, with macro UART_TX_PARITY_EN defined, insert the PARITY state after DATA, driving tx to the parity bit of the latched data bits for OVS ticks; parameter PARITY_ODD (default 0) selects even (0) or odd (1) parity.
REQ-027 SHALL, without UART_TX_PARITY_EN, contain no PARITY state, PARITY_ODD parameter or parity logic, and DATA goes directly to STOP.

Structure
REQ-028 SHALL take state encodings and the DBIT/OVS limits from a shared package uart_pkg, which the UART receiver also uses.
REQ-029 SHALL contain no sub-module; s_tick is generated externally by the existing mod-M counter instance.

Verification
REQ-030 With s_tick every cycle and din=0xA5, tx_start pulsed once, tx SHALL be 0,1,0,1,0,0,1,0,1,1 per 16 cycles, tx_done_tick SHALL pulse 160 cycles after START entry, and tx_busy SHALL be high throughout.
REQ-031 With UART_TX_PARITY_EN defined, PARITY_ODD=0 and din=0xA5, the parity bit SHALL be 0 and the frame SHALL be 176 ticks; with PARITY_ODD=1 the parity bit SHALL be 1.
REQ-032 With s_tick once every 4 cycles, OVS=16 and din=0x00, each bit SHALL last 64 cycles; a tx_start held high mid-frame SHALL not alter the frame.
REQ-033 With tx_start held high continuously, frames 0x55 then 0x3C SHALL run back-to-back, the second START beginning 1 cycle after tx_done_tick.
REQ-034 With rst asserted in DATA at bit 3, tx SHALL go to 1 and tx_busy to 0 without waiting for a clock, and no tx_done_tick SHALL occur.
REQ-035 With SB_TICK=32, the stop period SHALL be 32 ticks and tx_done_tick SHALL pulse on the 32nd stop tick.
